// File: rtl/alu_pkg.sv
// alu_pkg: shared types for the sequential ALU (opcodes, FSM states, flags)
// and the flag-reduction helper used on the registered result.
package alu_pkg;

  // Widest result flags_f can reduce; the ALU width must not exceed this.
  localparam int unsigned FLAG_MAXW = 64;

  typedef enum logic [3:0] {
    OP_ADD  = 4'd0,
    OP_SUB  = 4'd1,
    OP_ADDI = 4'd2,
    OP_LB   = 4'd3,
    OP_SB   = 4'd4,
    OP_MOVR = 4'd5,
    OP_ADC  = 4'd6,
    OP_NOR  = 4'd7,
    OP_XOR  = 4'd8,
    OP_AND  = 4'd9,
    OP_OR   = 4'd10,
    OP_SLL  = 4'd11,
    OP_SRL  = 4'd12,
    OP_EQ   = 4'd13,
    OP_LT   = 4'd14,
    OP_RXOR = 4'd15
  } alu_op_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_HOLD  = 2'd2
  } alu_state_e;

  typedef struct packed {
    logic pari;
    logic one;
    logic zero;
  } alu_flags_t;

  // Reduces the low w bits of r; r is the zero-extended result.
  function automatic alu_flags_t flags_f(input logic [FLAG_MAXW-1:0] r, input int w);
    alu_flags_t f;
    f.pari = 1'b0;
    f.one  = 1'b1;
    f.zero = 1'b1;
    for (int i = 0; i < int'(FLAG_MAXW); i++) begin
      if (i < w) begin
        f.pari = f.pari ^ r[i];
        f.one  = f.one & r[i];
        f.zero = f.zero & ~r[i];
      end
    end
    return f;
  endfunction

endpackage

// File: rtl/alu_shifter.sv
// alu_shifter: SLL/SRL unit for alu_seq. Shift amount clamps to W.
// Build option: ALU_FAST_SHIFT_EN selects a single-cycle barrel shifter;
// otherwise one bit is shifted per cycle and a count register tracks progress.
// res/co/done describe the value that will be held after the current edge,
// so the caller can register the final result on the same edge it completes.
module alu_shifter #(
  parameter int W = 8
) (
`ifndef ALU_FAST_SHIFT_EN
  input  logic         Clk,
  input  logic         Reset_n,
  input  logic         start,
`endif
  input  logic         dir_left,
  input  logic [W-1:0] a,
  input  logic [W-1:0] amt,
  output logic [W-1:0] res,
  output logic         co,
  output logic         done
);

  localparam int SHW = $clog2(W) + 1;

  logic [SHW-1:0] k;

  // Effective shift count, clamped so that over-range amounts clear the result.
  always_comb k = (amt >= W'(W)) ? SHW'(W) : amt[SHW-1:0];

`ifdef ALU_FAST_SHIFT_EN

  logic [W:0] l_ext;
  logic [W:0] r_ext;

  // Barrel shift with one guard bit that catches the last bit shifted out.
  always_comb begin
    l_ext = {1'b0, a} << k;
    r_ext = {a, 1'b0} >> k;
    if (dir_left) {co, res} = l_ext;
    else          {res, co} = r_ext;
  end

  assign done = 1'b1;

`else

  logic [W-1:0]   work_q, work_d;
  logic [SHW-1:0] cnt_q, cnt_d;
  logic           co_q, co_d;
  logic           left_q, left_d;

  // Single-bit step; returns {bit shifted out, shifted value}.
  function automatic logic [W:0] step(input logic [W-1:0] v, input logic l);
    return l ? {v, 1'b0} : {v[0], 1'b0, v[W-1:1]};
  endfunction

  // First step happens on the start edge so a k-bit shift finishes after k edges.
  always_comb begin
    work_d = work_q;
    cnt_d  = cnt_q;
    co_d   = co_q;
    left_d = left_q;
    if (start) begin
      left_d = dir_left;
      if (k == '0) begin
        work_d = a;
        co_d   = 1'b0;
        cnt_d  = '0;
      end else begin
        {co_d, work_d} = step(a, dir_left);
        cnt_d          = k - SHW'(1);
      end
    end else if (cnt_q != '0) begin
      {co_d, work_d} = step(work_q, left_q);
      cnt_d          = cnt_q - SHW'(1);
    end
  end

  // Working register and remaining count; reset abandons any shift in progress.
  always_ff @(posedge Clk) begin
    if (!Reset_n) begin
      work_q <= '0;
      cnt_q  <= '0;
      co_q   <= 1'b0;
      left_q <= 1'b0;
    end else begin
      work_q <= work_d;
      cnt_q  <= cnt_d;
      co_q   <= co_d;
      left_q <= left_d;
    end
  end

  assign res  = work_d;
  assign co   = co_d;
  assign done = (cnt_d == '0);

`endif

endmodule

// File: rtl/alu_seq.sv
// alu_seq: valid/ready ALU between register-file read and write-back.
// Non-shift ops complete in one cycle; shifts go through alu_shifter.
// Build option: ALU_FAST_SHIFT_EN makes shifts single-cycle (SHIFT unused).
//
// state | meaning
// IDLE  | no operation in flight
// SHIFT | iterative shift in progress, input side stalled
// HOLD  | result and flags presented until the consumer takes them
module alu_seq
  import alu_pkg::*;
#(
  parameter int W = 8
) (
  input  logic         Clk,
  input  logic         Reset_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  alu_op_e      alu_cmd,
  input  logic [W-1:0] inA,
  input  logic [W-1:0] inB,
  input  logic         sc_i,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] rslt,
  output logic         sc_o,
  output logic         pari,
  output logic         one,
  output logic         zero
);

  alu_state_e   state_q, state_d, issue_state;
  logic         accept, is_shift, load_alu, load_sh;
  logic         sh_done, sh_co;
  logic [W-1:0] sh_res, alu_res, imm_mag;
  logic         alu_co;
  alu_flags_t   flags;

  assign accept   = in_valid && in_ready;
  assign is_shift = (alu_cmd == OP_SLL) || (alu_cmd == OP_SRL);
  assign imm_mag  = {1'b0, inB[W-2:0]};

`ifndef ALU_FAST_SHIFT_EN
  logic sh_start;
  assign sh_start = accept && is_shift;
`endif

  alu_shifter #(.W(W)) u_shifter (
`ifndef ALU_FAST_SHIFT_EN
    .Clk      (Clk),
    .Reset_n  (Reset_n),
    .start    (sh_start),
`endif
    .dir_left (alu_cmd == OP_SLL),
    .a        (inA),
    .amt      (inB),
    .res      (sh_res),
    .co       (sh_co),
    .done     (sh_done)
  );

  // Single-cycle datapath for every op except the shifts.
  always_comb begin
    alu_res = '0;
    alu_co  = 1'b0;
    case (alu_cmd)
      OP_ADD:  {alu_co, alu_res} = {1'b0, inA} + {1'b0, inB};
      OP_SUB:  {alu_co, alu_res} = {1'b0, inA} - {1'b0, inB};
      OP_ADDI: begin
        if (inB[W-1]) {alu_co, alu_res} = {1'b0, inA} - {1'b0, imm_mag};
        else          {alu_co, alu_res} = {1'b0, inA} + {1'b0, inB};
      end
      OP_LB, OP_SB: alu_res = inA;
      OP_MOVR: alu_res = inB;
      OP_ADC:  {alu_co, alu_res} = {1'b0, inA} + {1'b0, inB} + {{W{1'b0}}, sc_i};
      OP_NOR:  alu_res = ~(inA | inB);
      OP_XOR:  alu_res = inA ^ inB;
      OP_AND:  alu_res = inA & inB;
      OP_OR:   alu_res = inA | inB;
      OP_EQ:   alu_res = {{(W-1){1'b0}}, inA == inB};
      OP_LT:   alu_res = {{(W-1){1'b0}}, inA < inB};
      OP_RXOR: alu_res = {{(W-1){1'b0}}, ^inB};
      default: ;
    endcase
  end

  // A shift that finishes on its accept edge goes straight to HOLD.
  assign issue_state = (is_shift && !sh_done) ? ST_SHIFT : ST_HOLD;

  // State register.
  always_ff @(posedge Clk) begin
    if (!Reset_n) state_q <= ST_IDLE;
    else          state_q <= state_d;
  end

  // Next-state logic; retire and re-issue can share one cycle in HOLD.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (accept) state_d = issue_state;
      ST_SHIFT: if (sh_done) state_d = ST_HOLD;
      ST_HOLD:  if (out_ready) state_d = accept ? issue_state : ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // Handshake outputs.
  always_comb begin
    in_ready  = Reset_n && (state_q == ST_IDLE || (state_q == ST_HOLD && out_ready));
    out_valid = (state_q == ST_HOLD);
  end

  assign load_alu = accept && !is_shift;
  assign load_sh  = sh_done && ((accept && is_shift) || state_q == ST_SHIFT);

  // Result register only changes when a new result becomes final.
  always_ff @(posedge Clk) begin
    if (!Reset_n) begin
      rslt <= '0;
      sc_o <= 1'b0;
    end else if (load_alu) begin
      rslt <= alu_res;
      sc_o <= alu_co;
    end else if (load_sh) begin
      rslt <= sh_res;
      sc_o <= sh_co;
    end
  end

  assign flags = flags_f(FLAG_MAXW'(rslt), W);
  assign pari  = flags.pari;
  assign one   = flags.one;
  assign zero  = flags.zero;

endmodule

// File: tb/tb_alu_seq.sv
// tb_alu_seq: directed vector table for alu_seq (W=8) plus hand-written
// sequences for back-to-back issue, backpressure, reset abort, and a W=16
// instance checked against a small arithmetic model.
module tb_alu_seq;
  import alu_pkg::*;

`ifdef ALU_FAST_SHIFT_EN
  localparam bit FAST = 1'b1;
`else
  localparam bit FAST = 1'b0;
`endif

  logic       Clk = 1'b0;
  logic       Reset_n;
  logic       in_valid, in_ready, sc_i, out_valid, out_ready, sc_o, pari, one, zero;
  alu_op_e    alu_cmd;
  logic [7:0] inA, inB, rslt;

  logic        valid16, ready16, ci16, ovalid16, oready16, co16, pari16, one16, zero16;
  alu_op_e     cmd16;
  logic [15:0] a16, b16, rslt16;

  int n_vec = 0;
  int n_bad = 0;

  always #5 Clk = ~Clk;

  alu_seq #(.W(8)) dut (
    .Clk(Clk), .Reset_n(Reset_n), .in_valid(in_valid), .in_ready(in_ready),
    .alu_cmd(alu_cmd), .inA(inA), .inB(inB), .sc_i(sc_i),
    .out_valid(out_valid), .out_ready(out_ready), .rslt(rslt), .sc_o(sc_o),
    .pari(pari), .one(one), .zero(zero)
  );

  alu_seq #(.W(16)) dut16 (
    .Clk(Clk), .Reset_n(Reset_n), .in_valid(valid16), .in_ready(ready16),
    .alu_cmd(cmd16), .inA(a16), .inB(b16), .sc_i(ci16),
    .out_valid(ovalid16), .out_ready(oready16), .rslt(rslt16), .sc_o(co16),
    .pari(pari16), .one(one16), .zero(zero16)
  );

  typedef struct {
    alu_op_e    op;
    logic [7:0] a;
    logic [7:0] b;
    logic       ci;
    logic [7:0] r;
    logic       co;
    int         lat;
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic issue8(input alu_op_e op, input logic [7:0] a, input logic [7:0] b, input logic ci,
                        output logic [7:0] r, output logic co, output logic [2:0] fl,
                        output int lat, output logic busy_ok);
    int guard;
    @(negedge Clk);
    alu_cmd = op; inA = a; inB = b; sc_i = ci; out_ready = 1'b1; in_valid = 1'b1;
    guard = 0;
    while (!in_ready && guard < 20) begin
      @(negedge Clk);
      guard++;
    end
    if (guard >= 20) chk("issue_wait", {31'd0, in_ready}, 32'd1);
    @(posedge Clk);
    #1 in_valid = 1'b0;
    lat = 1;
    busy_ok = 1'b1;
    @(negedge Clk);
    while (!out_valid && lat < 20) begin
      if (in_ready) busy_ok = 1'b0;
      @(negedge Clk);
      lat++;
    end
    r = rslt; co = sc_o; fl = {pari, one, zero};
  endtask

  task automatic issue16(input alu_op_e op, input logic [15:0] a, input logic [15:0] b,
                         output logic [15:0] r, output logic co, output int lat);
    @(negedge Clk);
    cmd16 = op; a16 = a; b16 = b; valid16 = 1'b1;
    @(posedge Clk);
    #1 valid16 = 1'b0;
    lat = 1;
    @(negedge Clk);
    while (!ovalid16 && lat < 20) begin
      @(negedge Clk);
      lat++;
    end
    r = rslt16; co = co16;
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [7:0]  r;
    logic        co, busy_ok, seen;
    logic [2:0]  fl;
    int          lat, exp_lat;
    logic [15:0] r16, pa[4], pb[4];
    logic [16:0] m17;
    alu_op_e     ops16[3];

    vecs.push_back('{OP_ADD,  8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1});
    vecs.push_back('{OP_SUB,  8'h05, 8'h07, 1'b0, 8'hFE, 1'b1, 1});
    vecs.push_back('{OP_ADDI, 8'h0A, 8'h83, 1'b0, 8'h07, 1'b0, 1});
    vecs.push_back('{OP_ADDI, 8'hF0, 8'h20, 1'b0, 8'h10, 1'b1, 1});
    vecs.push_back('{OP_ADDI, 8'h02, 8'h85, 1'b0, 8'hFD, 1'b1, 1});
    vecs.push_back('{OP_LB,   8'h5A, 8'h33, 1'b0, 8'h5A, 1'b0, 1});
    vecs.push_back('{OP_SB,   8'hA5, 8'h33, 1'b1, 8'hA5, 1'b0, 1});
    vecs.push_back('{OP_MOVR, 8'h11, 8'hC3, 1'b0, 8'hC3, 1'b0, 1});
    vecs.push_back('{OP_ADC,  8'hFE, 8'h01, 1'b1, 8'h00, 1'b1, 1});
    vecs.push_back('{OP_ADC,  8'h10, 8'h20, 1'b1, 8'h31, 1'b0, 1});
    vecs.push_back('{OP_NOR,  8'hF0, 8'h0F, 1'b0, 8'h00, 1'b0, 1});
    vecs.push_back('{OP_XOR,  8'hF0, 8'hFF, 1'b0, 8'h0F, 1'b0, 1});
    vecs.push_back('{OP_AND,  8'hCC, 8'hAA, 1'b0, 8'h88, 1'b0, 1});
    vecs.push_back('{OP_OR,   8'hC0, 8'h03, 1'b0, 8'hC3, 1'b0, 1});
    vecs.push_back('{OP_SLL,  8'h83, 8'h03, 1'b0, 8'h18, 1'b0, 3});
    vecs.push_back('{OP_SRL,  8'h80, 8'h09, 1'b0, 8'h00, 1'b1, 8});
    vecs.push_back('{OP_SLL,  8'h5A, 8'h00, 1'b0, 8'h5A, 1'b0, 1});
    vecs.push_back('{OP_SRL,  8'h81, 8'h01, 1'b0, 8'h40, 1'b1, 1});
    vecs.push_back('{OP_SLL,  8'h81, 8'h08, 1'b0, 8'h00, 1'b1, 8});
    vecs.push_back('{OP_SRL,  8'hF0, 8'h04, 1'b0, 8'h0F, 1'b0, 4});
    vecs.push_back('{OP_EQ,   8'h3C, 8'h3C, 1'b0, 8'h01, 1'b0, 1});
    vecs.push_back('{OP_EQ,   8'h3C, 8'h3D, 1'b0, 8'h00, 1'b0, 1});
    vecs.push_back('{OP_LT,   8'h02, 8'hFF, 1'b0, 8'h01, 1'b0, 1});
    vecs.push_back('{OP_LT,   8'hFF, 8'h02, 1'b0, 8'h00, 1'b0, 1});
    vecs.push_back('{OP_RXOR, 8'h00, 8'h07, 1'b0, 8'h01, 1'b0, 1});
    vecs.push_back('{OP_RXOR, 8'hFF, 8'h0F, 1'b0, 8'h00, 1'b0, 1});

    Reset_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1; alu_cmd = OP_ADD;
    inA = '0; inB = '0; sc_i = 1'b0;
    valid16 = 1'b0; oready16 = 1'b1; cmd16 = OP_ADD; a16 = '0; b16 = '0; ci16 = 1'b0;

    // reset state
    repeat (3) @(negedge Clk);
    chk("rst in_ready", {31'd0, in_ready}, 32'd0);
    chk("rst out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst rslt", {24'd0, rslt}, 32'd0);
    chk("rst sc_o", {31'd0, sc_o}, 32'd0);
    chk("rst flags", {29'd0, pari, one, zero}, 32'd1);
    chk("rst16 in_ready", {31'd0, ready16}, 32'd0);
    Reset_n = 1'b1;

    // vector table
    foreach (vecs[i]) begin
      issue8(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].ci, r, co, fl, lat, busy_ok);
      exp_lat = FAST ? 1 : vecs[i].lat;
      chk($sformatf("v%0d %s rslt", i, vecs[i].op.name()), {24'd0, r}, {24'd0, vecs[i].r});
      chk($sformatf("v%0d %s sc_o", i, vecs[i].op.name()), {31'd0, co}, {31'd0, vecs[i].co});
      chk($sformatf("v%0d %s latency", i, vecs[i].op.name()), lat, exp_lat);
      chk($sformatf("v%0d %s flags", i, vecs[i].op.name()), {29'd0, fl},
          {29'd0, ^vecs[i].r, &vecs[i].r, vecs[i].r == 8'h00});
      chk($sformatf("v%0d %s in_ready_busy", i, vecs[i].op.name()), {31'd0, busy_ok}, 32'd1);
    end

    // back-to-back single-cycle ops
    @(negedge Clk);
    out_ready = 1'b1; in_valid = 1'b1; alu_cmd = OP_ADD; inA = 8'h01; inB = 8'h02; sc_i = 1'b0;
    @(negedge Clk);
    chk("b2b ov0", {31'd0, out_valid}, 32'd1);
    chk("b2b r0", {24'd0, rslt}, 32'h03);
    chk("b2b in_ready", {31'd0, in_ready}, 32'd1);
    alu_cmd = OP_SUB; inA = 8'h09; inB = 8'h04;
    @(negedge Clk);
    chk("b2b ov1", {31'd0, out_valid}, 32'd1);
    chk("b2b r1", {24'd0, rslt}, 32'h05);
    alu_cmd = OP_OR; inA = 8'h30; inB = 8'h03;
    @(negedge Clk);
    chk("b2b r2", {24'd0, rslt}, 32'h33);
    in_valid = 1'b0;
    @(negedge Clk);
    chk("b2b drain", {31'd0, out_valid}, 32'd0);

    // backpressure, then retire and accept in one cycle
    out_ready = 1'b0; in_valid = 1'b1; alu_cmd = OP_XOR; inA = 8'hF0; inB = 8'hFF;
    @(negedge Clk);
    in_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("bp%0d out_valid", i), {31'd0, out_valid}, 32'd1);
      chk($sformatf("bp%0d rslt", i), {24'd0, rslt}, 32'h0F);
      chk($sformatf("bp%0d in_ready", i), {31'd0, in_ready}, 32'd0);
      @(negedge Clk);
    end
    out_ready = 1'b1; in_valid = 1'b1; alu_cmd = OP_AND; inA = 8'hFF; inB = 8'h3C;
    #1;
    chk("bp release in_ready", {31'd0, in_ready}, 32'd1);
    chk("bp release rslt", {24'd0, rslt}, 32'h0F);
    @(negedge Clk);
    chk("bp next out_valid", {31'd0, out_valid}, 32'd1);
    chk("bp next rslt", {24'd0, rslt}, 32'h3C);
    in_valid = 1'b0;
    @(negedge Clk);
    chk("bp drain", {31'd0, out_valid}, 32'd0);

    // reset during a 5-bit shift
    out_ready = 1'b1; in_valid = 1'b1; alu_cmd = OP_SLL; inA = 8'h01; inB = 8'h05;
    @(posedge Clk);
    #1 in_valid = 1'b0;
    @(negedge Clk);
    @(negedge Clk);
    Reset_n = 1'b0;
    @(posedge Clk);
    #1;
    chk("abort out_valid", {31'd0, out_valid}, 32'd0);
    chk("abort rslt", {24'd0, rslt}, 32'd0);
    chk("abort zero", {31'd0, zero}, 32'd1);
    chk("abort in_ready", {31'd0, in_ready}, 32'd0);
    @(negedge Clk);
    Reset_n = 1'b1;
    seen = 1'b0;
    repeat (10) begin
      @(negedge Clk);
      if (out_valid) seen = 1'b1;
    end
    chk("abort no emit", {31'd0, seen}, 32'd0);
    issue8(OP_ADD, 8'h40, 8'h02, 1'b0, r, co, fl, lat, busy_ok);
    chk("post-abort rslt", {24'd0, r}, 32'h42);

    // W=16 instance against a reference model
    pa = '{16'hFFFF, 16'h1234, 16'h8000, 16'h00FF};
    pb = '{16'h0001, 16'h4321, 16'h8000, 16'hFF00};
    ops16 = '{OP_ADD, OP_SUB, OP_LT};
    for (int i = 0; i < 4; i++) begin
      for (int j = 0; j < 3; j++) begin
        issue16(ops16[j], pa[i], pb[i], r16, co, lat);
        case (ops16[j])
          OP_ADD:  m17 = {1'b0, pa[i]} + {1'b0, pb[i]};
          OP_SUB:  m17 = {1'b0, pa[i]} - {1'b0, pb[i]};
          default: m17 = {16'h0000, pa[i] < pb[i]};
        endcase
        chk($sformatf("w16 %s %0d rslt", ops16[j].name(), i), {16'd0, r16}, {16'd0, m17[15:0]});
        chk($sformatf("w16 %s %0d sc_o", ops16[j].name(), i), {31'd0, co}, {31'd0, m17[16]});
        chk($sformatf("w16 %s %0d latency", ops16[j].name(), i), lat, 32'd1);
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
